sprite_mask_animator: RTL and testbench



---
 rtl/sprite_pkg.sv | 25 ++
 rtl/sprite_mask_animator_if.sv | 40 ++++
 rtl/xilinx_single_port_ram_read_first.sv | 51 +++++
 rtl/sprite_mask_animator.sv | 158 +++++++++++++++
 tb/tb_sprite_mask_animator.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared constants, types and address helper for the sprite renderers.
// Also used by the multi-colour sprite variant.
package sprite_pkg;

  localparam int unsigned SPRITE_LAT = 3;
  localparam int unsigned HCOUNT_W   = 11;
  localparam int unsigned VCOUNT_W   = 10;
  localparam int unsigned REL_W      = 12;

  typedef logic [1:0] scale_t;

  // Linear ROM address: shape-major, frame-minor, row-major image layout
  function automatic int unsigned sprite_addr(
    input int unsigned shape,
    input int unsigned frame,
    input int unsigned row,
    input int unsigned col,
    input int unsigned num_frames,
    input int unsigned height,
    input int unsigned width
  );
    return ((shape * num_frames + frame) * height + row) * width + col;
  endfunction

endpackage

// File: rtl/sprite_mask_animator_if.sv
// Pixel-pipeline bundle between the video timing source, the sprite block
// and the compositor.
interface sprite_mask_animator_if
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SHAPES = 4,
  parameter int unsigned NUM_FRAMES = 4
);

  localparam int unsigned SHAPE_W = $clog2(NUM_SHAPES);
  localparam int unsigned FRAME_W = $clog2(NUM_FRAMES);

  logic [HCOUNT_W-1:0] hcount_in;
  logic [VCOUNT_W-1:0] vcount_in;
  logic                new_frame_in;
  logic [HCOUNT_W-1:0] x_in;
  logic [VCOUNT_W-1:0] y_in;
  logic [SHAPE_W-1:0]  shape_in;
  logic                flip_in;
  scale_t              scale_in;
  logic                anim_en_in;

  logic                draw_out;
  logic [HCOUNT_W-1:0] hcount_out;
  logic [VCOUNT_W-1:0] vcount_out;
  logic [FRAME_W-1:0]  frame_idx_out;

  modport master (
    output hcount_in, vcount_in, new_frame_in, x_in, y_in,
           shape_in, flip_in, scale_in, anim_en_in,
    input  draw_out, hcount_out, vcount_out, frame_idx_out
  );

  modport slave (
    input  hcount_in, vcount_in, new_frame_in, x_in, y_in,
           shape_in, flip_in, scale_in, anim_en_in,
    output draw_out, hcount_out, vcount_out, frame_idx_out
  );

endinterface

// File: rtl/xilinx_single_port_ram_read_first.sv
// Single-port read-first block RAM; HIGH_PERFORMANCE adds an output register
// with synchronous reset, giving a 2-cycle read latency.
module xilinx_single_port_ram_read_first #(
  parameter int unsigned RAM_WIDTH       = 18,
  parameter int unsigned RAM_DEPTH       = 1024,
  parameter string       RAM_PERFORMANCE = "HIGH_PERFORMANCE",
  parameter string       INIT_FILE       = ""
) (
  input  logic [$clog2(RAM_DEPTH)-1:0] i_addra,
  input  logic [RAM_WIDTH-1:0]         i_dina,
  input  logic                         i_clka,
  input  logic                         i_wea,
  input  logic                         i_ena,
  input  logic                         i_rsta,
  input  logic                         i_regcea,
  output logic [RAM_WIDTH-1:0]         o_douta
);

  logic [RAM_WIDTH-1:0] r_mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] r_ram_data;

  always_ff @(posedge i_clka) begin
    if (i_ena) begin
      if (i_wea) begin
        r_mem[i_addra] <= i_dina;
      end
      r_ram_data <= r_mem[i_addra];
    end
  end

  // Image contents are attached by the implementation flow's memory-init step
  if (INIT_FILE != "") begin : g_init_image
  end

  if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_no_output_register
    assign o_douta = r_ram_data;
  end else begin : g_output_register
    logic [RAM_WIDTH-1:0] r_douta;

    always_ff @(posedge i_clka) begin
      if (i_rsta) begin
        r_douta <= '0;
      end else if (i_regcea) begin
        r_douta <= r_ram_data;
      end
    end

    assign o_douta = r_douta;
  end

endmodule

// File: rtl/sprite_mask_animator.sv
// Animated 1-bit-mask sprite with frame-synchronous attribute latching,
// power-of-2 upscaling and horizontal mirroring; 3-cycle pixel latency.
module sprite_mask_animator
  import sprite_pkg::*;
#(
  parameter int unsigned WIDTH       = 128,
  parameter int unsigned HEIGHT      = 128,
  parameter int unsigned NUM_SHAPES  = 4,
  parameter int unsigned NUM_FRAMES  = 4,
  parameter int unsigned HOLD_FRAMES = 8,
  parameter int unsigned MAX_SCALE   = 2,
  parameter string       INIT_FILE   = "sprite_anim_mask.mem"
) (
  input logic                    pixel_clk_in,
  input logic                    rst_in,
  sprite_mask_animator_if.slave  io_bus
);

  localparam int unsigned COL_W   = $clog2(WIDTH);
  localparam int unsigned ROW_W   = $clog2(HEIGHT);
  localparam int unsigned SHAPE_W = $clog2(NUM_SHAPES);
  localparam int unsigned FRAME_W = $clog2(NUM_FRAMES);
  localparam int unsigned HOLD_W  = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam int unsigned DEPTH   = WIDTH * HEIGHT * NUM_SHAPES * NUM_FRAMES;
  localparam int unsigned AW      = $clog2(DEPTH);

  logic [HCOUNT_W-1:0] r_x_l;
  logic [VCOUNT_W-1:0] r_y_l;
  logic [SHAPE_W-1:0]  r_shape_l;
  logic                r_flip_l;
  scale_t              r_scale_l;
  logic [HOLD_W-1:0]   r_hold;
  logic [FRAME_W-1:0]  r_frame_idx;

  scale_t              w_scale_clamped;
  logic [REL_W-1:0]    w_rel_x;
  logic [REL_W-1:0]    w_rel_y;
  logic [REL_W-1:0]    w_span_x;
  logic [REL_W-1:0]    w_span_y;
  logic                w_in_box;
  logic [COL_W-1:0]    w_col;
  logic [COL_W-1:0]    w_col_f;
  logic [ROW_W-1:0]    w_row;
  logic [AW-1:0]       w_addr;

  logic [AW-1:0]       r_addr;
  logic                r_in_box_d1;
  logic                r_in_box_d2;
  logic                w_rom_dout;

  logic [HCOUNT_W-1:0] r_hcount_d [SPRITE_LAT];
  logic [VCOUNT_W-1:0] r_vcount_d [SPRITE_LAT];

  assign w_scale_clamped = (32'(io_bus.scale_in) > MAX_SCALE) ? scale_t'(MAX_SCALE)
                                                              : io_bus.scale_in;

  // Attribute latches and animation sequencer, all updated on the frame pulse
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      r_x_l       <= '0;
      r_y_l       <= '0;
      r_shape_l   <= '0;
      r_flip_l    <= 1'b0;
      r_scale_l   <= '0;
      r_hold      <= '0;
      r_frame_idx <= '0;
    end else if (io_bus.new_frame_in) begin
      r_x_l     <= io_bus.x_in;
      r_y_l     <= io_bus.y_in;
      r_shape_l <= io_bus.shape_in;
      r_flip_l  <= io_bus.flip_in;
      r_scale_l <= w_scale_clamped;
      if (io_bus.anim_en_in) begin
        if (io_bus.shape_in != r_shape_l) begin
          r_hold      <= '0;
          r_frame_idx <= '0;
        end else if (r_hold == HOLD_W'(HOLD_FRAMES - 1)) begin
          r_hold      <= '0;
          r_frame_idx <= (r_frame_idx == FRAME_W'(NUM_FRAMES - 1)) ? '0
                                                                  : r_frame_idx + FRAME_W'(1);
        end else begin
          r_hold <= r_hold + HOLD_W'(1);
        end
      end
    end
  end

  // Stage 0: the extra top bit acts as a sign, so pixels left of or above the
  // sprite never alias into the box and partial off-screen sprites just clip.
  assign w_rel_x  = {1'b0, io_bus.hcount_in} - {1'b0, r_x_l};
  assign w_rel_y  = {2'b0, io_bus.vcount_in} - {2'b0, r_y_l};
  assign w_span_x = REL_W'(WIDTH) << r_scale_l;
  assign w_span_y = REL_W'(HEIGHT) << r_scale_l;
  assign w_in_box = !w_rel_x[REL_W-1] && (w_rel_x < w_span_x) &&
                    !w_rel_y[REL_W-1] && (w_rel_y < w_span_y);

  assign w_col   = COL_W'(w_rel_x >> r_scale_l);
  assign w_row   = ROW_W'(w_rel_y >> r_scale_l);
  assign w_col_f = r_flip_l ? (COL_W'(WIDTH - 1) - w_col) : w_col;
  assign w_addr  = AW'(sprite_addr(32'(r_shape_l), 32'(r_frame_idx), 32'(w_row),
                                   32'(w_col_f), NUM_FRAMES, HEIGHT, WIDTH));

  // Stage 1 address register; in_box is the only state that needs clearing
  always_ff @(posedge pixel_clk_in) begin
    r_addr <= w_addr;
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      r_in_box_d1 <= 1'b0;
      r_in_box_d2 <= 1'b0;
    end else begin
      r_in_box_d1 <= w_in_box;
      r_in_box_d2 <= r_in_box_d1;
    end
  end

  // Stages 2-3: the ROM output register is cleared whenever the pixel was
  // outside the box, so its output already is draw_out.
  xilinx_single_port_ram_read_first #(
    .RAM_WIDTH       (1),
    .RAM_DEPTH       (DEPTH),
    .RAM_PERFORMANCE ("HIGH_PERFORMANCE"),
    .INIT_FILE       (INIT_FILE)
  ) u_rom (
    .i_addra  (r_addr),
    .i_dina   (1'b0),
    .i_clka   (pixel_clk_in),
    .i_wea    (1'b0),
    .i_ena    (1'b1),
    .i_rsta   (rst_in | ~r_in_box_d2),
    .i_regcea (1'b1),
    .o_douta  (w_rom_dout)
  );

  // Coordinate delay line matched to the ROM path
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < SPRITE_LAT; i++) begin
        r_hcount_d[i] <= '0;
        r_vcount_d[i] <= '0;
      end
    end else begin
      r_hcount_d[0] <= io_bus.hcount_in;
      r_vcount_d[0] <= io_bus.vcount_in;
      for (int i = 1; i < SPRITE_LAT; i++) begin
        r_hcount_d[i] <= r_hcount_d[i-1];
        r_vcount_d[i] <= r_vcount_d[i-1];
      end
    end
  end

  assign io_bus.draw_out      = w_rom_dout;
  assign io_bus.hcount_out    = r_hcount_d[SPRITE_LAT-1];
  assign io_bus.vcount_out    = r_vcount_d[SPRITE_LAT-1];
  assign io_bus.frame_idx_out = r_frame_idx;

endmodule

// File: tb/tb_sprite_mask_animator.sv
// Directed bench for sprite_mask_animator: latching, latency, scaling,
// mirroring, clipping, animation sequencing and mid-line reset.
module tb_sprite_mask_animator;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  sprite_mask_animator_if #(.NUM_SHAPES(4), .NUM_FRAMES(4)) bus ();

  sprite_mask_animator #(
    .WIDTH       (128),
    .HEIGHT      (128),
    .NUM_SHAPES  (4),
    .NUM_FRAMES  (4),
    .HOLD_FRAMES (2),
    .MAX_SCALE   (2),
    .INIT_FILE   ("sprite_anim_mask.mem")
  ) dut (
    .pixel_clk_in (clk),
    .rst_in       (rst),
    .io_bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic probe(input string tag, input int unsigned h, input int unsigned v,
                       input int unsigned exp);
    bus.hcount_in = 11'(h);
    bus.vcount_in = 10'(v);
    repeat (3) step();
    check({tag, " draw"}, 32'(bus.draw_out), exp);
    check({tag, " hout"}, 32'(bus.hcount_out), h);
    check({tag, " vout"}, 32'(bus.vcount_out), v);
  endtask

  task automatic set_attr(input int unsigned x, input int unsigned y, input int unsigned shape,
                          input bit flip, input int unsigned scale, input bit anim);
    bus.x_in       = 11'(x);
    bus.y_in       = 10'(y);
    bus.shape_in   = 2'(shape);
    bus.flip_in    = flip;
    bus.scale_in   = 2'(scale);
    bus.anim_en_in = anim;
  endtask

  task automatic pulse();
    bus.new_frame_in = 1'b1;
    step();
    bus.new_frame_in = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int unsigned exp_seq [9];

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    exp_seq = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    rst = 1'b1;
    bus.hcount_in    = '0;
    bus.vcount_in    = '0;
    bus.new_frame_in = 1'b0;
    set_attr(0, 0, 0, 1'b0, 0, 1'b0);

    // Sprite images: shape0/f0 (3,2), shape1/f0 (3,2), shape0/f1 (5,5), shape2/f0 (12,2)
    dut.u_rom.r_mem[259]    <= 1'b1;
    dut.u_rom.r_mem[65795]  <= 1'b1;
    dut.u_rom.r_mem[17029]  <= 1'b1;
    dut.u_rom.r_mem[131340] <= 1'b1;

    repeat (2) step();
    check("rst draw", 32'(bus.draw_out), 0);
    check("rst hout", 32'(bus.hcount_out), 0);
    check("rst vout", 32'(bus.vcount_out), 0);
    check("rst frame", 32'(bus.frame_idx_out), 0);
    rst = 1'b0;

    // Basic hit and neighbours
    set_attr(100, 50, 1, 1'b0, 0, 1'b0);
    pulse();
    probe("hit", 103, 52, 1);
    probe("right", 104, 52, 0);
    probe("left", 102, 52, 0);
    probe("below", 103, 53, 0);

    // Exact 3-cycle latency
    probe("pre", 104, 52, 0);
    bus.hcount_in = 11'd103;
    bus.vcount_in = 10'd52;
    repeat (2) step();
    check("lat2 draw", 32'(bus.draw_out), 0);
    check("lat2 hout", 32'(bus.hcount_out), 104);
    step();
    check("lat3 draw", 32'(bus.draw_out), 1);
    check("lat3 hout", 32'(bus.hcount_out), 103);

    // Mid-frame change is invisible until the pulse
    bus.x_in = 11'd400;
    probe("nolatch old", 103, 52, 1);
    probe("nolatch new", 403, 52, 0);
    pulse();
    probe("latch new", 403, 52, 1);
    probe("latch old", 103, 52, 0);

    // Scale 1: pixel (3,2) covers h 6-7, v 4-5
    set_attr(0, 0, 0, 1'b0, 1, 1'b0);
    pulse();
    probe("s1 a", 6, 4, 1);
    probe("s1 b", 7, 5, 1);
    probe("s1 c", 5, 4, 0);
    probe("s1 d", 8, 5, 0);
    probe("s1 e", 6, 3, 0);

    // Scale 3 clamps to 2: pixel (3,2) covers h 12-15, v 8-11
    set_attr(0, 0, 0, 1'b0, 3, 1'b0);
    pulse();
    probe("s3 a", 12, 8, 1);
    probe("s3 b", 15, 11, 1);
    probe("s3 c", 16, 8, 0);
    probe("s3 d", 24, 16, 0);

    // Mirror: ROM col 3 lands at rel_x 124
    set_attr(0, 0, 0, 1'b1, 0, 1'b0);
    pulse();
    probe("flip hit", 124, 2, 1);
    probe("flip orig", 3, 2, 0);

    // Right-edge clip, no wrap to the left side
    set_attr(1270, 0, 0, 1'b0, 0, 1'b0);
    pulse();
    probe("clip hit", 1273, 2, 1);
    probe("clip miss", 1272, 2, 0);
    set_attr(1270, 0, 2, 1'b0, 0, 1'b0);
    pulse();
    probe("clip nowrap", 2, 2, 0);
    set_attr(0, 0, 2, 1'b0, 0, 1'b0);
    pulse();
    probe("shape2 hit", 12, 2, 1);

    // Animation sequence with HOLD_FRAMES=2
    do_reset();
    set_attr(0, 0, 0, 1'b0, 0, 1'b1);
    for (int k = 0; k < 9; k++) begin
      check($sformatf("anim seq %0d", k), 32'(bus.frame_idx_out), exp_seq[k]);
      if (k == 2) begin
        probe("frame1 hit", 5, 5, 1);
        probe("frame1 miss", 3, 2, 0);
      end
      pulse();
    end

    // Shape change on pulse 5 forces frame 0, then freeze and resume
    do_reset();
    set_attr(0, 0, 0, 1'b0, 0, 1'b1);
    repeat (4) pulse();
    check("pre shape chg", 32'(bus.frame_idx_out), 2);
    bus.shape_in = 2'd1;
    pulse();
    check("shape chg", 32'(bus.frame_idx_out), 0);
    repeat (2) pulse();
    check("after chg", 32'(bus.frame_idx_out), 1);
    bus.anim_en_in = 1'b0;
    repeat (3) pulse();
    check("frozen", 32'(bus.frame_idx_out), 1);
    bus.anim_en_in = 1'b1;
    repeat (2) pulse();
    check("resumed", 32'(bus.frame_idx_out), 2);

    // Reset mid-line: latches return to origin, shape 0, frame 0
    do_reset();
    probe("pre rst", 3, 2, 1);
    rst = 1'b1;
    step();
    check("rst0 draw", 32'(bus.draw_out), 0);
    check("rst0 hout", 32'(bus.hcount_out), 0);
    rst = 1'b0;
    step();
    check("rst1 draw", 32'(bus.draw_out), 0);
    check("rst1 hout", 32'(bus.hcount_out), 0);
    step();
    check("rst2 draw", 32'(bus.draw_out), 0);
    step();
    check("rst3 draw", 32'(bus.draw_out), 1);
    check("rst3 hout", 32'(bus.hcount_out), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
